// File: rtl/mmio_port_responder_if.sv
// Data-memory bus as seen by the MMIO responder: CPU-side load/store request
// and the responder's combinational reply.
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address,
        output WriteData,
        output MemWrite,
        output MemRead,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  Address,
        input  WriteData,
        input  MemWrite,
        input  MemRead,
        output ReadData,
        output Hit
    );
endinterface

// File: rtl/mmio_port_responder.sv
// MMIO responder on the data-memory bus: output port, synchronized input port with
// rising-edge flags, a compare timer and a registered level interrupt.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR     = 32'h1001_0000,
    parameter int          PORT_IN_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    mmio_port_responder_if.slave     bus,
    input  logic [PORT_IN_WIDTH-1:0] PortIn,
    output logic [31:0]              PortOut,
    output logic                     Irq
);
    localparam logic [2:0] IDX_PORT_OUT   = 3'd0;
    localparam logic [2:0] IDX_PORT_IN    = 3'd1;
    localparam logic [2:0] IDX_EDGE_FLAGS = 3'd2;
    localparam logic [2:0] IDX_TIMER_CTRL = 3'd3;
    localparam logic [2:0] IDX_TIMER_CMP  = 3'd4;
    localparam logic [2:0] IDX_TIMER_CNT  = 3'd5;
    localparam logic [2:0] IDX_STATUS     = 3'd6;
    localparam logic [2:0] IDX_EDGE_MASK  = 3'd7;
    localparam logic [PORT_IN_WIDTH-1:0] PIN_ZERO = {PORT_IN_WIDTH{1'b0}};

    function automatic logic [31:0] zext_pin(input logic [PORT_IN_WIDTH-1:0] v);
        logic [31:0] r;
        r = 32'h0;
        r[PORT_IN_WIDTH-1:0] = v;
        return r;
    endfunction

    logic                     w_hit;
    logic [2:0]               w_idx;
    logic                     w_wr;
    logic [7:0]               w_wsel;
    logic                     w_unused_addr;
    logic [PORT_IN_WIDTH-1:0] w_wr_pin;
    logic [PORT_IN_WIDTH-1:0] w_rise;
    logic                     w_match_evt;
    logic [31:0]              w_rdata;

    logic [PORT_IN_WIDTH-1:0] r_s1;
    logic [PORT_IN_WIDTH-1:0] r_s2;
    logic [PORT_IN_WIDTH-1:0] r_s3;
    logic [31:0]              r_port_out;
    logic [PORT_IN_WIDTH-1:0] r_edge;
    logic [PORT_IN_WIDTH-1:0] r_mask;
    logic                     r_en;
    logic                     r_auto;
    logic                     r_ie;
    logic [31:0]              r_cmp;
    logic [31:0]              r_cnt;
    logic                     r_match;
    logic                     r_irq;

    logic [31:0]              w_port_out_nxt;
    logic [PORT_IN_WIDTH-1:0] w_edge_nxt;
    logic [PORT_IN_WIDTH-1:0] w_mask_nxt;
    logic                     w_en_nxt;
    logic                     w_auto_nxt;
    logic                     w_ie_nxt;
    logic [31:0]              w_cmp_nxt;
    logic [31:0]              w_cnt_nxt;
    logic                     w_match_nxt;
    logic                     w_irq_nxt;

    assign w_hit         = (bus.Address[31:5] == BASE_ADDR[31:5]);
    assign w_idx         = bus.Address[4:2];
    assign w_wr          = bus.MemWrite & w_hit;
    assign w_wr_pin      = bus.WriteData[PORT_IN_WIDTH-1:0];
    assign w_unused_addr = ^bus.Address[1:0];
    assign w_rise        = r_s2 & ~r_s3;
    assign w_match_evt   = r_en & (r_cnt == r_cmp);

    // One-hot write strobe per register, only for in-window stores
    always_comb begin
        w_wsel = 8'h00;
        if (w_wr) begin
            w_wsel[w_idx] = 1'b1;
        end else begin
            w_wsel = 8'h00;
        end
    end

    // Next-state logic; hardware sets beat W1C clears, CPU writes beat timer progress
    always_comb begin
        w_port_out_nxt = r_port_out;
        w_mask_nxt     = r_mask;
        w_cmp_nxt      = r_cmp;
        w_en_nxt       = r_en;
        w_auto_nxt     = r_auto;
        w_ie_nxt       = r_ie;
        w_cnt_nxt      = r_cnt;

        if (w_wsel[IDX_PORT_OUT]) begin
            w_port_out_nxt = bus.WriteData;
        end else begin
            w_port_out_nxt = r_port_out;
        end

        if (w_wsel[IDX_EDGE_MASK]) begin
            w_mask_nxt = w_wr_pin;
        end else begin
            w_mask_nxt = r_mask;
        end

        if (w_wsel[IDX_TIMER_CMP]) begin
            w_cmp_nxt = bus.WriteData;
        end else begin
            w_cmp_nxt = r_cmp;
        end

        if (w_wsel[IDX_TIMER_CTRL]) begin
            w_en_nxt   = bus.WriteData[0];
            w_auto_nxt = bus.WriteData[1];
            w_ie_nxt   = bus.WriteData[2];
        end else if (w_match_evt && !r_auto) begin
            w_en_nxt = 1'b0;
        end else begin
            w_en_nxt = r_en;
        end

        if (w_wsel[IDX_TIMER_CNT]) begin
            w_cnt_nxt = 32'h0;
        end else if (!r_en) begin
            w_cnt_nxt = r_cnt;
        end else if (!w_match_evt) begin
            w_cnt_nxt = r_cnt + 32'd1;
        end else if (r_auto) begin
            w_cnt_nxt = 32'h0;
        end else begin
            w_cnt_nxt = r_cnt;
        end

        w_edge_nxt  = (r_edge & ~(w_wsel[IDX_EDGE_FLAGS] ? w_wr_pin : PIN_ZERO)) | w_rise;
        w_match_nxt = (r_match & ~(w_wsel[IDX_STATUS] & bus.WriteData[0])) | w_match_evt;
        w_irq_nxt   = (|(r_edge & r_mask)) | (r_match & r_ie);
    end

    // Load data is combinational so the MEM stage can use it in the same cycle
    always_comb begin
        w_rdata = 32'h0;
        if (bus.MemRead && w_hit) begin
            case (w_idx)
                IDX_PORT_OUT:   w_rdata = r_port_out;
                IDX_PORT_IN:    w_rdata = zext_pin(r_s2);
                IDX_EDGE_FLAGS: w_rdata = zext_pin(r_edge);
                IDX_TIMER_CTRL: w_rdata = {29'h0, r_ie, r_auto, r_en};
                IDX_TIMER_CMP:  w_rdata = r_cmp;
                IDX_TIMER_CNT:  w_rdata = r_cnt;
                IDX_STATUS:     w_rdata = {31'h0, r_match};
                IDX_EDGE_MASK:  w_rdata = zext_pin(r_mask);
                default:        w_rdata = 32'h0;
            endcase
        end else begin
            w_rdata = 32'h0;
        end
    end

    // Three-stage input synchronizer; s3 only serves the edge detector
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= PIN_ZERO;
            r_s2 <= PIN_ZERO;
            r_s3 <= PIN_ZERO;
        end else begin
            r_s1 <= PortIn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Architectural register state and the registered interrupt
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_port_out <= 32'h0;
            r_edge     <= PIN_ZERO;
            r_mask     <= PIN_ZERO;
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_ie       <= 1'b0;
            r_cmp      <= 32'h0;
            r_cnt      <= 32'h0;
            r_match    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_port_out <= w_port_out_nxt;
            r_edge     <= w_edge_nxt;
            r_mask     <= w_mask_nxt;
            r_en       <= w_en_nxt;
            r_auto     <= w_auto_nxt;
            r_ie       <= w_ie_nxt;
            r_cmp      <= w_cmp_nxt;
            r_cnt      <= w_cnt_nxt;
            r_match    <= w_match_nxt;
            r_irq      <= w_irq_nxt;
        end
    end

    assign bus.ReadData = w_rdata;
    assign bus.Hit      = w_hit;
    assign PortOut      = r_port_out;
    assign Irq          = r_irq;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed and randomized bench for mmio_port_responder, checked against a
// register-level model of the MMIO window.
module tb_mmio_port_responder;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          W    = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] PortIn;
    logic [31:0]  PortOut;
    logic         Irq;

    mmio_port_responder_if bus_if ();

    mmio_port_responder #(.BASE_ADDR(BASE), .PORT_IN_WIDTH(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_if.slave),
        .PortIn  (PortIn),
        .PortOut (PortOut),
        .Irq     (Irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: register contents plus the PortIn values seen at the last three edges
    logic [31:0]  m_port_out, m_cmp, m_cnt;
    logic [W-1:0] m_edge, m_mask;
    logic [W-1:0] m_hist [3];
    logic         m_en, m_auto, m_ie, m_match, m_irq;

    function automatic logic in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd32);
    endfunction

    function automatic logic [31:0] m_reg(input int idx);
        case (idx)
            0:       return m_port_out;
            1:       return {24'h0, m_hist[1]};
            2:       return {24'h0, m_edge};
            3:       return {29'h0, m_ie, m_auto, m_en};
            4:       return m_cmp;
            5:       return m_cnt;
            6:       return {31'h0, m_match};
            7:       return {24'h0, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata();
        if (bus_if.MemRead && in_window(bus_if.Address))
            return m_reg(int'((bus_if.Address - BASE) / 32'd4));
        else
            return 32'h0;
    endfunction

    task automatic model_reset();
        m_port_out = 32'h0; m_cmp = 32'h0; m_cnt = 32'h0;
        m_edge = '0; m_mask = '0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
        m_en = 1'b0; m_auto = 1'b0; m_ie = 1'b0; m_match = 1'b0; m_irq = 1'b0;
    endtask

    // Advance the model over one clock edge using the inputs currently driven
    task automatic model_edge();
        logic         hit, hit_match, new_irq;
        int           idx;
        logic [31:0]  wd;
        logic [W-1:0] rise;
        hit       = in_window(bus_if.Address);
        idx       = int'((bus_if.Address - BASE) / 32'd4);
        wd        = bus_if.WriteData;
        new_irq   = (|(m_edge & m_mask)) | (m_match & m_ie);
        rise      = m_hist[1] & ~m_hist[2];
        hit_match = m_en && (m_cnt == m_cmp);
        if (m_en) begin
            if (hit_match) begin
                if (m_auto) m_cnt = 32'h0;
                else        m_en  = 1'b0;
            end else begin
                m_cnt = m_cnt + 32'd1;
            end
        end
        if (bus_if.MemWrite && hit) begin
            case (idx)
                0: m_port_out = wd;
                2: m_edge = m_edge & ~wd[W-1:0];
                3: {m_ie, m_auto, m_en} = wd[2:0];
                4: m_cmp = wd;
                5: m_cnt = 32'h0;
                6: if (wd[0]) m_match = 1'b0;
                7: m_mask = wd[W-1:0];
                default: ;
            endcase
        end
        m_edge = m_edge | rise;
        if (hit_match) m_match = 1'b1;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = PortIn;
        m_irq = new_irq;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        check({tag, ".PortOut"},  PortOut, m_port_out);
        check({tag, ".Irq"},      {31'h0, Irq}, {31'h0, m_irq});
        check({tag, ".Hit"},      {31'h0, bus_if.Hit}, {31'h0, in_window(bus_if.Address)});
        check({tag, ".ReadData"}, bus_if.ReadData, m_rdata());
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.Address = 32'h0; bus_if.WriteData = 32'h0;
        bus_if.MemWrite = 1'b0; bus_if.MemRead = 1'b0;
    endtask

    task automatic wr(input int idx, input logic [31:0] data);
        bus_if.Address = BASE + 32'(idx * 4); bus_if.WriteData = data;
        bus_if.MemWrite = 1'b1; bus_if.MemRead = 1'b0;
        step();
        idle();
    endtask

    task automatic rd(input int idx, input logic [31:0] exp, input string tag);
        bus_if.Address = BASE + 32'(idx * 4); bus_if.MemRead = 1'b1; bus_if.MemWrite = 1'b0;
        #1;
        check(tag, bus_if.ReadData, exp);
        check({tag, ".model"}, bus_if.ReadData, m_rdata());
        idle();
    endtask

    initial begin
        logic [31:0] exp_seq [6];
        reset = 1'b0;
        PortIn = '0;
        idle();
        model_reset();
        #22;
        reset = 1'b1;
        #1;

        // Reset / idle state
        check("rst.PortOut", PortOut, 32'h0);
        check("rst.Irq", {31'h0, Irq}, 32'h0);
        check("rst.Hit0", {31'h0, bus_if.Hit}, 32'h0);
        rd(0, 32'h0, "rst.rd_port_out");

        // Output port and window boundary
        wr(0, 32'hA5A5_00FF);
        check("po.PortOut", PortOut, 32'hA5A5_00FF);
        rd(0, 32'hA5A5_00FF, "po.rd");
        bus_if.Address = BASE + 32'h20; bus_if.WriteData = 32'h1234_5678; bus_if.MemWrite = 1'b1;
        #1;
        check("oow.Hit", {31'h0, bus_if.Hit}, 32'h0);
        step();
        idle();
        check("oow.PortOut", PortOut, 32'hA5A5_00FF);
        bus_if.Address = BASE - 32'd4; bus_if.MemRead = 1'b1;
        #1;
        check("below.Hit", {31'h0, bus_if.Hit}, 32'h0);
        check("below.ReadData", bus_if.ReadData, 32'h0);
        idle();

        // Input synchronizer, edge flags and edge interrupt
        wr(7, 32'h0000_0001);
        PortIn = 8'h81;
        step();
        rd(1, 32'h0, "pin.e1");
        step();
        rd(1, 32'h81, "pin.e2");
        rd(2, 32'h0, "edge.e2");
        step();
        rd(2, 32'h81, "edge.e3");
        check("edge.irq_e3", {31'h0, Irq}, 32'h0);
        step();
        check("edge.irq_e4", {31'h0, Irq}, 32'h1);
        wr(2, 32'h0000_0001);
        rd(2, 32'h80, "edge.w1c");
        step();
        check("edge.irq_drop", {31'h0, Irq}, 32'h0);

        // One-shot timer
        wr(4, 32'd5);
        wr(3, 32'h5);
        rd(5, 32'd0, "os.cnt0");
        for (int k = 1; k <= 5; k++) begin
            step();
            rd(5, 32'(k), "os.cnt");
        end
        rd(3, 32'h5, "os.ctrl_run");
        step();
        rd(6, 32'h1, "os.match");
        rd(3, 32'h4, "os.en_clr");
        rd(5, 32'd5, "os.hold");
        step();
        check("os.irq", {31'h0, Irq}, 32'h1);
        rd(5, 32'd5, "os.hold2");
        wr(6, 32'h1);
        rd(6, 32'h0, "os.w1c");
        step();
        check("os.irq_drop", {31'h0, Irq}, 32'h0);

        // Auto-reload timer and W1C colliding with a match
        wr(4, 32'd2);
        wr(5, 32'h0);
        wr(3, 32'h3);
        rd(5, 32'd0, "ar.cnt0");
        exp_seq = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd2, 32'd0};
        for (int k = 0; k < 6; k++) begin
            step();
            rd(5, exp_seq[k], "ar.seq");
        end
        rd(6, 32'h1, "ar.match");
        wr(6, 32'h1);
        rd(6, 32'h0, "ar.w1c");
        step();
        rd(5, 32'd2, "ar.pre");
        wr(6, 32'h1);
        rd(6, 32'h1, "ar.set_wins");
        rd(5, 32'd0, "ar.reload");

        // Asynchronous reset in the middle of a count
        wr(3, 32'h0);
        wr(5, 32'h0);
        wr(4, 32'd100);
        wr(3, 32'h1);
        for (int k = 0; k < 3; k++) step();
        rd(5, 32'd3, "mid.cnt3");
        reset = 1'b0;
        model_reset();
        #1;
        check("mid.PortOut", PortOut, 32'h0);
        rd(5, 32'h0, "mid.cnt_rst");
        rd(3, 32'h0, "mid.ctrl_rst");
        reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) step();
        rd(5, 32'h0, "mid.cnt_idle");

        // Randomized accesses against the model
        for (int n = 0; n < 600; n++) begin
            int          sel;
            logic [31:0] a, wd;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE + $urandom_range(0, 31);
            else if (sel == 8) a = BASE + 32'd32 + $urandom_range(0, 31);
            else               a = $urandom;
            wd = $urandom;
            if (in_window(a) && ((a - BASE) / 32'd4) == 32'd4) wd = $urandom_range(0, 6);
            bus_if.Address   = a;
            bus_if.WriteData = wd;
            bus_if.MemWrite  = ($urandom_range(0, 2) == 0);
            bus_if.MemRead   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) PortIn = W'($urandom);
            #1;
            chk_model("rnd.comb");
            step();
            chk_model("rnd.seq");
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus, i.e. the target end of the load/store accesses issued from the MEM stage.
- Owns the output port register, a synchronized input port with rising-edge capture, and a compare timer.
- Drives a hit flag so the top level can choose between this block's ReadData and DataMemory's ReadData, and an interrupt line for later use.

Parameters:
- BASE_ADDR, 32'h1001_0000: byte base of the 8-word register window. Must be 32-byte aligned.
- PORT_IN_WIDTH, 8: width of PortIn (1..32).

Ports:
- clk  input  1: clock, rising edge.
- reset  input  1: asynchronous, active-low reset.
- Address  input  32: byte address from the EX/MEM ALU result.
- WriteData  input  32: store data.
- MemWrite  input  1: store strobe, sampled on the clk rising edge.
- MemRead  input  1: load strobe.
- ReadData  output  32: load data, combinational.
- Hit  output  1: Address lies in the window.
- PortIn  input  PORT_IN_WIDTH: asynchronous external inputs.
- PortOut  output  32: output port register.
- Irq  output  1: level interrupt.

Behaviour:
- Decode: Hit = (Address[31:5] == BASE_ADDR[31:5]). Register index = Address[4:2]; Address[1:0] ignored.
- Writes take effect on the clk edge when MemWrite && Hit. Reads have no side effects.
- ReadData = selected register when MemRead && Hit, else 32'h0. Combinational, so it is usable in the same MEM cycle.
- Register map (index: name, access):
  - 0: PORT_OUT, RW 32 bits; drives PortOut directly.
  - 1: PORT_IN, RO; stage-2 synchronized PortIn, zero-extended.
  - 2: EDGE_FLAGS, W1C; bit i is set on a rising edge of synchronized PortIn[i].
  - 3: TIMER_CTRL, RW; bit0 EN, bit1 AUTO_RELOAD, bit2 TIMER_IE; other bits read 0.
  - 4: TIMER_CMP, RW 32 bits.
  - 5: TIMER_CNT, RO; any write clears it to 0.
  - 6: STATUS, W1C; bit0 MATCH (sticky).
  - 7: EDGE_MASK, RW, PORT_IN_WIDTH bits.
- Synchronizer: three flop stages s1 -> s2 -> s3.
  - PORT_IN reads s2, so a PortIn change becomes visible 2 clk edges later.
  - Edge detect = s2 & ~s3, latched into EDGE_FLAGS at the next edge (3 edges after the input change).
- Timer:
  - EN=1 and CNT != CMP: CNT increments by 1 per clk.
  - EN=1 and CNT == CMP: MATCH is set at that edge.
    - AUTO_RELOAD=1: CNT becomes 0.
    - AUTO_RELOAD=0: CNT holds and EN is cleared to 0.
  - EN=0: CNT holds.
  - CNT wraps 32'hFFFF_FFFF -> 0 when CMP is never reached.
  - CMP=0 with EN=1 gives a match every cycle under auto-reload.
- Irq = (|(EDGE_FLAGS & EDGE_MASK)) | (MATCH & TIMER_IE), registered, so it asserts one edge after the flag sets.
- Simultaneous events:
  - A hardware set of EDGE_FLAGS or MATCH in the same cycle as a W1C write to that bit: set wins.
  - A CPU write to TIMER_CNT in the same cycle as an increment or reload: the write (clear to 0) wins.
  - A CPU write of EN=0 in the same cycle as a match: MATCH still sets and EN reads 0.
- Reset (reset=0, asynchronous): all registers, sync flops, CNT, flags, PortOut, Irq = 0. Reset asserted mid-count abandons the count with no pending match. Registers accept writes from the first edge after reset is released.
- Non-hit accesses: no state change; ReadData = 0.

Test Plan:
- Reset then idle: PortOut=0, Irq=0, Hit=0 for Address=0. Load of BASE+0x00 -> ReadData=0.
- Store 32'hA5A5_00FF to BASE+0x00 -> PortOut=32'hA5A5_00FF after the edge. Load of BASE+0x00 returns the same value. Store to BASE+0x20 (out of window) -> PortOut unchanged, Hit=0.
- PortIn 8'h00 -> 8'h81 with EDGE_MASK=8'h01:
  - PORT_IN reads 8'h81 after 2 edges.
  - EDGE_FLAGS reads 8'h81 after 3 edges.
  - Irq=1 one edge later.
  - Writing 8'h01 to EDGE_FLAGS -> flags read 8'h80 and Irq drops.
- Timer one-shot: CMP=5, CTRL=3'b101 -> CNT reads 0,1,..,5, MATCH=1, EN reads 0, CNT holds at 5, Irq=1. Writing 1 to STATUS clears MATCH and Irq.
- Timer auto-reload: CMP=2, CTRL=3'b011 -> CNT sequence 0,1,2,0,1,2. A W1C of MATCH issued in the same cycle as a match leaves MATCH=1.
- Assert reset mid-count (CNT=3): CNT, CTRL and PortOut go to 0 immediately without waiting for a clk edge. After release, CNT stays 0 until EN is written.
